// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter block.
// Holds the 4-bit ALU control codes, the arbiter FSM state type, the result
// returned for unsupported control codes, and a helper that tells whether a
// control code is one of the supported operations.
package alu_pkg;

  localparam logic [3:0] AluCtrlAnd = 4'b0000;
  localparam logic [3:0] AluCtrlOr  = 4'b0001;
  localparam logic [3:0] AluCtrlAdd = 4'b0010;
  localparam logic [3:0] AluCtrlSub = 4'b0110;
  localparam logic [3:0] AluCtrlSlt = 4'b0111;
  localparam logic [3:0] AluCtrlNor = 4'b1100;

  localparam logic [31:0] AluIllegal = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

  function automatic logic ctrl_is_legal(logic [3:0] ctrl);
    case (ctrl)
      AluCtrlAnd, AluCtrlOr, AluCtrlAdd, AluCtrlSub, AluCtrlSlt, AluCtrlNor: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters and the arbiter.
// Requester n: i_req<n>_valid/o_req<n>_ready handshake with operands
// i_req<n>_a/_b and control i_req<n>_ctrl; o_rsp<n>_valid/i_rsp<n>_ready
// response handshake. Shared response data o_rsp_result/o_rsp_zero, and
// o_busy while an operation is in flight.
// With ALU_ARB_ILLEGAL_EN defined, o_rsp_err flags an unsupported control code.
// Modports: slave (arbiter side), master (requester side).
interface alu_arbiter_if;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [31:0] i_req0_a;
  logic [31:0] i_req0_b;
  logic [3:0]  i_req0_ctrl;
  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [31:0] i_req1_a;
  logic [31:0] i_req1_b;
  logic [3:0]  i_req1_ctrl;
  logic        o_rsp0_valid;
  logic        i_rsp0_ready;
  logic        o_rsp1_valid;
  logic        i_rsp1_ready;
  logic [31:0] o_rsp_result;
  logic        o_rsp_zero;
  logic        o_busy;
`ifdef ALU_ARB_ILLEGAL_EN
  logic        o_rsp_err;
`endif

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_ctrl,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
    output o_rsp_result, o_rsp_zero, o_busy
`ifdef ALU_ARB_ILLEGAL_EN
    , output o_rsp_err
`endif
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_ctrl,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
    input  o_rsp_result, o_rsp_zero, o_busy
`ifdef ALU_ARB_ILLEGAL_EN
    , input o_rsp_err
`endif
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU.
// Ports: a_i, b_i operands; ctrl_i 4-bit control code; result_o result;
// zero_o high when result_o is zero. Unsupported codes yield AluIllegal.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = AluIllegal;
    case (ctrl_i)
      AluCtrlAnd: result_o = a_i & b_i;
      AluCtrlOr:  result_o = a_i | b_i;
      AluCtrlAdd: result_o = a_i + b_i;
      AluCtrlSub: result_o = a_i - b_i;
      AluCtrlSlt: result_o = {31'd0, (a_i < b_i)};
      AluCtrlNor: result_o = ~(a_i | b_i);
      default:    result_o = AluIllegal;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU.
// One operation in flight: IDLE grants one requester (ready is combinational),
// EXEC registers the ALU result, RESP holds it until the owner accepts.
// Ports: i_clk clock; i_rst asynchronous active-high reset; bus slave modport
// of alu_arbiter_if carrying both request/response handshakes.
// Parameter RR_EN: 1 = round-robin on ties, 0 = requester 0 always wins.
// Macro ALU_ARB_ILLEGAL_EN adds o_rsp_err for unsupported control codes.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst,
  alu_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;   // requester whose op is in flight
  logic        last_q, last_d;     // last granted requester
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic [1:0]  grant;
  logic [31:0] alu_result;
  logic        alu_zero;

  alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .ctrl_i   (ctrl_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Reset gates the grant so ready cannot rise while reset is held.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle && !i_rst) begin
      if (bus.i_req0_valid && bus.i_req1_valid) begin
        grant = (RR_EN && !last_q) ? 2'b10 : 2'b01;
      end else begin
        grant = {bus.i_req1_valid, bus.i_req0_valid};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          state_d = StExec;
          owner_d = grant[1];
          last_d  = grant[1];
          a_d     = grant[1] ? bus.i_req1_a    : bus.i_req0_a;
          b_d     = grant[1] ? bus.i_req1_b    : bus.i_req0_b;
          ctrl_d  = grant[1] ? bus.i_req1_ctrl : bus.i_req0_ctrl;
        end
      end
      StExec: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = StResp;
      end
      StResp: begin
        if (owner_q ? bus.i_rsp1_ready : bus.i_rsp0_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;  // requester 0 wins the first tie
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.o_req0_ready = grant[0];
  assign bus.o_req1_ready = grant[1];
  assign bus.o_rsp0_valid = (state_q == StResp) && !owner_q;
  assign bus.o_rsp1_valid = (state_q == StResp) && owner_q;
  assign bus.o_rsp_result = result_q;
  assign bus.o_rsp_zero   = zero_q;
  assign bus.o_busy       = (state_q != StIdle);

`ifdef ALU_ARB_ILLEGAL_EN
  logic err_q, err_d;

  // Captured with the result so it stays valid through RESP.
  always_comb begin
    err_d = err_q;
    if (state_q == StExec) begin
      err_d = !ctrl_is_legal(ctrl_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.o_rsp_err = (state_q == StResp) && err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level
// reference model (pending requests per requester, last-granted pointer,
// arithmetic ALU function and fixed operation timeline).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if ifc ();
  alu_arbiter_if ifc_fp ();

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc_fp)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bit          pend [2];
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [3:0]  op_c [2];
  int          last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] c);
    return c == 4'd0 || c == 4'd1 || c == 4'd2 || c == 4'd6 || c == 4'd7 || c == 4'd12;
  endfunction

  task automatic drive_reqs();
    ifc.i_req0_valid = pend[0];
    ifc.i_req0_a     = op_a[0];
    ifc.i_req0_b     = op_b[0];
    ifc.i_req0_ctrl  = op_c[0];
    ifc.i_req1_valid = pend[1];
    ifc.i_req1_a     = op_a[1];
    ifc.i_req1_b     = op_b[1];
    ifc.i_req1_ctrl  = op_c[1];
  endtask

  task automatic set_op(input int n, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
    pend[n] = 1'b1;
    op_c[n] = c;
    op_a[n] = a;
    op_b[n] = b;
  endtask

  task automatic new_op(input int n);
    logic [3:0] codes [8];
    logic [31:0] a;
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
    a = $urandom();
    set_op(n, codes[$urandom_range(0, 7)], a, ($urandom_range(0, 3) == 0) ? a : $urandom());
  endtask

  // One arbitration round. Entered and left 1 time unit after a rising edge,
  // with the DUT in IDLE. bp = cycles the owner withholds rsp ready.
  task automatic run_round(input int bp, input bit raise_other);
    int w;
    logic [31:0] exp_r;
    bit exp_err;
    drive_reqs();
    if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
    else w = pend[1] ? 1 : 0;
    exp_r   = ref_alu(op_c[w], op_a[w], op_b[w]);
    exp_err = !ref_legal(op_c[w]);
    @(negedge clk);
    check_eq("grant_ready0", 32'(ifc.o_req0_ready), 32'(w == 0));
    check_eq("grant_ready1", 32'(ifc.o_req1_ready), 32'(w == 1));
    check_eq("idle_busy", 32'(ifc.o_busy), 32'd0);
    @(posedge clk);
    #1;
    pend[w] = 1'b0;
    last    = w;
    if (raise_other && !pend[1 - w]) new_op(1 - w);
    drive_reqs();
    @(negedge clk);
    check_eq("exec_busy", 32'(ifc.o_busy), 32'd1);
    check_eq("exec_ready", 32'({ifc.o_req1_ready, ifc.o_req0_ready}), 32'd0);
    check_eq("exec_rsp_valid", 32'({ifc.o_rsp1_valid, ifc.o_rsp0_valid}), 32'd0);
    @(posedge clk);
    for (int i = 0; i <= bp; i++) begin
      #1;
      // The non-owner's ready toggles randomly and must be ignored.
      if (w == 0) begin
        ifc.i_rsp0_ready = (i == bp);
        ifc.i_rsp1_ready = 1'($urandom_range(0, 1));
      end else begin
        ifc.i_rsp1_ready = (i == bp);
        ifc.i_rsp0_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check_eq("rsp_valid0", 32'(ifc.o_rsp0_valid), 32'(w == 0));
      check_eq("rsp_valid1", 32'(ifc.o_rsp1_valid), 32'(w == 1));
      check_eq("rsp_result", ifc.o_rsp_result, exp_r);
      check_eq("rsp_zero", 32'(ifc.o_rsp_zero), 32'(exp_r == 32'd0));
      check_eq("resp_busy", 32'(ifc.o_busy), 32'd1);
      check_eq("resp_ready", 32'({ifc.o_req1_ready, ifc.o_req0_ready}), 32'd0);
`ifdef ALU_ARB_ILLEGAL_EN
      check_eq("rsp_err", 32'(ifc.o_rsp_err), 32'(exp_err));
`endif
      @(posedge clk);
    end
    #1;
    ifc.i_rsp0_ready = 1'b0;
    ifc.i_rsp1_ready = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    last = 1;
    for (int n = 0; n < 2; n++) set_op(n, 4'd0, 32'd0, 32'd0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    ifc.i_rsp0_ready    = 1'b0;
    ifc.i_rsp1_ready    = 1'b0;
    ifc_fp.i_req0_valid = 1'b0;
    ifc_fp.i_req1_valid = 1'b0;
    ifc_fp.i_req0_a     = 32'd1;
    ifc_fp.i_req0_b     = 32'd2;
    ifc_fp.i_req0_ctrl  = 4'd2;
    ifc_fp.i_req1_a     = 32'd9;
    ifc_fp.i_req1_b     = 32'd9;
    ifc_fp.i_req1_ctrl  = 4'd6;
    ifc_fp.i_rsp0_ready = 1'b0;
    ifc_fp.i_rsp1_ready = 1'b0;

    // Tie held through reset: no ready while reset is asserted.
    set_op(0, 4'd6, 32'd7, 32'd7);
    set_op(1, 4'd6, 32'd7, 32'd7);
    drive_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'({ifc.o_req1_ready, ifc.o_req0_ready}), 32'd0);
    check_eq("rst_busy", 32'(ifc.o_busy), 32'd0);
    check_eq("rst_rsp_valid", 32'({ifc.o_rsp1_valid, ifc.o_rsp0_valid}), 32'd0);
    check_eq("rst_result", ifc.o_rsp_result, 32'd0);
    check_eq("rst_zero", 32'(ifc.o_rsp_zero), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_round(0, 1'b0);              // tie -> requester 0
    run_round(0, 1'b0);              // then requester 1
    set_op(0, 4'd2, 32'd5, 32'd3);   // single op, result 8
    run_round(0, 1'b0);
    set_op(0, 4'd1, 32'h00F0, 32'h0F00);
    set_op(1, 4'd0, 32'hFFFF_0000, 32'h1234_5678);
    run_round(0, 1'b0);              // second tie -> requester 1
    run_round(0, 1'b0);

    // Backpressure on requester 0 while requester 1 waits.
    set_op(0, 4'd12, 32'h0, 32'h1);
    run_round(5, 1'b1);
    run_round(0, 1'b0);

    set_op(0, 4'd2, 32'hFFFF_FFFF, 32'd1);
    run_round(0, 1'b0);
    set_op(1, 4'd6, 32'd0, 32'd1);
    run_round(0, 1'b0);
    set_op(0, 4'd7, 32'd1, 32'hFFFF_FFFF);
    run_round(0, 1'b0);
    set_op(0, 4'd7, 32'hFFFF_FFFF, 32'd1);
    run_round(0, 1'b0);
    set_op(1, 4'd3, 32'd4, 32'd4);
    run_round(0, 1'b0);

    // Reset while the response is pending.
    set_op(0, 4'd2, 32'd10, 32'd20);
    drive_reqs();
    @(negedge clk);
    check_eq("rr_grant0", 32'(ifc.o_req0_ready), 32'd1);
    @(posedge clk);
    #1;
    pend[0] = 1'b0;
    last    = 0;
    drive_reqs();
    @(posedge clk);
    @(negedge clk);
    check_eq("rr_rsp_before", 32'(ifc.o_rsp0_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rr_rsp_drop", 32'(ifc.o_rsp0_valid), 32'd0);
    check_eq("rr_busy_drop", 32'(ifc.o_busy), 32'd0);
    check_eq("rr_result_clr", ifc.o_rsp_result, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    last = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rr_no_stale", 32'({ifc.o_rsp1_valid, ifc.o_rsp0_valid, ifc.o_busy}), 32'd0);
      @(posedge clk);
      #1;
    end
    set_op(1, 4'd2, 32'd100, 32'd23);
    run_round(0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      for (int n = 0; n < 2; n++) if (!pend[n] && $urandom_range(0, 1) == 1) new_op(n);
      if (!pend[0] && !pend[1]) new_op(int'($urandom_range(0, 1)));
      run_round(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    while (pend[0] || pend[1]) run_round(0, 1'b0);

    // Fixed priority: requester 0 wins every tie.
    ifc_fp.i_req0_valid = 1'b1;
    ifc_fp.i_req1_valid = 1'b1;
    @(negedge clk);
    check_eq("fp_ready0_a", 32'(ifc_fp.o_req0_ready), 32'd1);
    check_eq("fp_ready1_a", 32'(ifc_fp.o_req1_ready), 32'd0);
    @(posedge clk);
    #1;
    ifc_fp.i_req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("fp_rsp0", 32'(ifc_fp.o_rsp0_valid), 32'd1);
    check_eq("fp_result", ifc_fp.o_rsp_result, 32'd3);
    ifc_fp.i_rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc_fp.i_rsp0_ready = 1'b0;
    ifc_fp.i_req0_valid = 1'b1;
    @(negedge clk);
    check_eq("fp_ready0_b", 32'(ifc_fp.o_req0_ready), 32'd1);
    check_eq("fp_ready1_b", 32'(ifc_fp.o_req1_ready), 32'd0);
    @(posedge clk);
    #1;
    ifc_fp.i_req0_valid = 1'b0;
    ifc_fp.i_req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 SHALL have port: i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports, per requester n in {0,1}: i_req<n>_valid  input  1  operation request.
REQ-005 SHALL have ports: o_req<n>_ready  output  1  request accepted (grant) this cycle.
REQ-006 SHALL have ports: i_req<n>_a, i_req<n>_b  input  32  operands; i_req<n>_ctrl  input  4  ALU control code.
REQ-007 SHALL have ports: o_rsp<n>_valid  output  1  result available; i_rsp<n>_ready  input  1  result consumed.
REQ-008 SHALL have shared ports: o_rsp_result  output  32  and o_rsp_zero  output  1, meaningful only with a rsp valid.
REQ-009 SHALL have port: o_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one operation in flight.
REQ-011 IDLE: if any i_req<n>_valid, SHALL assert exactly one o_req<n>_ready combinationally, latch a/b/ctrl and owner id at the clock edge, go EXEC.
REQ-012 o_req<n>_ready SHALL be low in EXEC and RESP; requests there SHALL wait (valid held by requester).
REQ-013 EXEC: SHALL present latched operands to the ALU, register result and zero, go RESP.
REQ-014 RESP: SHALL assert o_rsp<owner>_valid only; other o_rsp valid low; result/zero stable until handshake.
REQ-015 RESP with i_rsp<owner>_ready high SHALL return to IDLE next edge; ready of non-owner SHALL be ignored.
REQ-016 Latency: grant at edge T, o_rsp valid from cycle after edge T+1; min three cycles per operation, no back-to-back grant.
REQ-017 Both valid in IDLE with RR_EN=1: grant requester != last granted; pointer updates only on grant.
REQ-018 RR_EN=0: requester 0 always wins simultaneous requests.
REQ-019 ALU semantics SHALL be: 0000 AND, 0001 OR, 0010 ADD (mod 2^32), 0110 SUB (mod 2^32), 0111 unsigned less-than -> 1/0, 1100 NOR, other -> 32'hDEADBEEF; zero = (result == 0).

Reset
REQ-020 i_rst high SHALL immediately force IDLE, all o_req ready and o_rsp valid low, o_busy 0, result/zero 0, RR pointer to requester 1 (so requester 0 wins first tie).
REQ-021 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response after reset release.
REQ-022 First grant SHALL be possible in the first IDLE cycle after reset deasserts.

Configuration
REQ-023 Macro ALU_ARB_ILLEGAL_EN SHALL, when defined, add output o_rsp_err (1 bit), high with rsp valid when latched ctrl is not one of the six legal codes; result still DEADBEEF.
REQ-024 Without ALU_ARB_ILLEGAL_EN, o_rsp_err SHALL not exist and behaviour is otherwise identical.

Structure
REQ-025 Shared package alu_pkg SHALL hold the 4-bit ALU control code constants, the FSM state enum and the ILLEGAL result constant.
REQ-026 Block SHALL instantiate the existing alu module as its single sub-module; no other arithmetic logic.

Verification
REQ-027 Single op: req0 a=5, b=3, ctrl=0010 -> ready0 same cycle, rsp0_valid two edges later, result 8, zero 0.
REQ-028 Tie: req0 and req1 valid at once after reset, ctrl 0110 a=b=7 both -> req0 served first (result 0, zero 1), then req1; a second tie -> req1 first.
REQ-029 Backpressure: hold rsp0_ready low 5 cycles -> rsp0_valid and result stable, req1 ready stays low, o_busy 1.
REQ-030 Reset in RESP: assert i_rst -> rsp valid drops immediately; after release no stale response, next req granted.
REQ-031 Boundaries: ADD FFFFFFFF+1 -> 0, zero 1; SUB 0-1 -> FFFFFFFF; SLT 1 vs FFFFFFFF -> 1.
REQ-032 Illegal ctrl 0011 -> result DEADBEEF; with ALU_ARB_ILLEGAL_EN, o_rsp_err 1.
